// File: rtl/rv64g_l1_vlsu_refill_engine.sv
// ---------------------------------------------------------------------------
// rv64g_l1_vlsu_refill_engine
//
// Single-outstanding L1 line refill engine sitting behind the VLSU miss
// handler. One request is accepted in IDLE, turned into a TileLink-C
// AcquireBlock on channel A, the 8-beat GrantData on channel D is streamed
// into the data-array fill port, tag/permission is committed, GrantAck is
// sent on channel E and refill_done_o is pulsed back to the miss handler.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   refill_*                 request from / completion to the miss handler
//   busy_o                   high whenever a transaction is in flight
//   a_*                      TileLink channel A (AcquireBlock)
//   d_*                      TileLink channel D (GrantData)
//   e_*                      TileLink channel E (GrantAck)
//   fill_*                   L1 data-array beat writes and tag/state commit
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for refill_req_i; captures line address and write intent
// ACQ    | AcquireBlock held on channel A until accepted
// GRANT  | consuming 8 GrantData beats, writing good beats to the fill port
// ACK    | GrantAck held on channel E until accepted
// DONE   | one-cycle completion pulse with error status and tag commit
// ---------------------------------------------------------------------------
module rv64g_l1_vlsu_refill_engine #(
  parameter int unsigned      TAG_W     = 53,
  parameter int unsigned      INDEX_W   = 5,
  parameter int unsigned      SRC_W     = 4,
  parameter int unsigned      SINK_W    = 4,
  parameter logic [SRC_W-1:0] SOURCE_ID = SRC_W'(2)
) (
  input  logic               clk_i,
  input  logic               rst_ni,

  input  logic               refill_req_i,
  input  logic [63:0]        refill_addr_i,
  input  logic               refill_write_i,
  output logic               refill_done_o,
  output logic               refill_err_o,
  output logic               busy_o,

  output logic               a_valid_o,
  input  logic               a_ready_i,
  output logic [2:0]         a_opcode_o,
  output logic [2:0]         a_param_o,
  output logic [3:0]         a_size_o,
  output logic [SRC_W-1:0]   a_source_o,
  output logic [63:0]        a_address_o,

  input  logic               d_valid_i,
  output logic               d_ready_o,
  input  logic [2:0]         d_opcode_i,
  input  logic [1:0]         d_param_i,
  input  logic [SRC_W-1:0]   d_source_i,
  input  logic [SINK_W-1:0]  d_sink_i,
  input  logic               d_denied_i,
  input  logic               d_corrupt_i,
  input  logic [63:0]        d_data_i,

  output logic               e_valid_o,
  input  logic               e_ready_i,
  output logic [SINK_W-1:0]  e_sink_o,

  output logic               fill_we_o,
  output logic [INDEX_W-1:0] fill_index_o,
  output logic [2:0]         fill_beat_o,
  output logic [63:0]        fill_data_o,
  output logic               fill_commit_o,
  output logic [TAG_W-1:0]   fill_tag_o,
  output logic [1:0]         fill_perm_o
);

  localparam int unsigned LINE_W = TAG_W + INDEX_W;

  localparam logic [2:0] OP_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] OP_GRANT_DATA    = 3'd5;
  localparam logic [3:0] LINE_SIZE_LOG2   = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_GRANT,
    S_ACK,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_q;
  logic                write_q;
  logic [2:0]          beat_q;
  logic                err_q;
  logic [SINK_W-1:0]   sink_q;
  logic [1:0]          cap_q;

  logic                d_fire;
  logic                beat_ok;

  // Offset bits inside the line carry no meaning for a whole-line refill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^refill_addr_i[63-LINE_W:0];

  // Every beat presented in GRANT is consumed, even a malformed one, so the
  // beat counter stays aligned with the responder's 8-beat burst.
  assign d_fire  = (state_q == S_GRANT) && d_valid_i;
  assign beat_ok = (d_opcode_i == OP_GRANT_DATA) && (d_source_i == SOURCE_ID);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    busy_o        = 1'b1;
    a_valid_o     = 1'b0;
    d_ready_o     = 1'b0;
    e_valid_o     = 1'b0;
    refill_done_o = 1'b0;
    refill_err_o  = 1'b0;
    fill_commit_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (refill_req_i) begin
          state_d = S_ACQ;
        end
      end
      S_ACQ: begin
        a_valid_o = 1'b1;
        if (a_ready_i) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        d_ready_o = 1'b1;
        if (d_valid_i && (beat_q == 3'd7)) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        e_valid_o = 1'b1;
        if (e_ready_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        refill_done_o = 1'b1;
        refill_err_o  = err_q;
        fill_commit_o = !err_q;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Transaction context: line address, intent, beat count, error, grant info
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q  <= '0;
      write_q <= 1'b0;
      beat_q  <= 3'd0;
      err_q   <= 1'b0;
      sink_q  <= '0;
      cap_q   <= 2'd0;
    end else begin
      if ((state_q == S_IDLE) && refill_req_i) begin
        line_q  <= refill_addr_i[63 -: LINE_W];
        write_q <= refill_write_i;
        // Clear the previous grant so a bad first beat cannot leak stale
        // sink/cap values into this transaction.
        sink_q  <= '0;
        cap_q   <= 2'd0;
      end

      if (d_fire) begin
        beat_q <= beat_q + 3'd1;
        if (!beat_ok || d_denied_i || d_corrupt_i) begin
          err_q <= 1'b1;
        end
        if (beat_ok && (beat_q == 3'd0)) begin
          sink_q <= d_sink_i;
          cap_q  <= d_param_i;
        end
      end

      if (state_q == S_DONE) begin
        err_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Channel payloads
  // ---------------------------------------------------------------------
  assign a_opcode_o  = OP_ACQUIRE_BLOCK;
  assign a_size_o    = LINE_SIZE_LOG2;
  assign a_source_o  = SOURCE_ID;
  assign a_param_o   = {2'b00, write_q};
  assign a_address_o = {line_q, {(64 - LINE_W){1'b0}}};

  assign e_sink_o    = sink_q;

  // Fill write is combinational with the D handshake so no beat buffer is
  // needed; data is gated so the port reads zero when no write is in flight.
  assign fill_we_o    = d_fire && beat_ok;
  assign fill_beat_o  = beat_q;
  assign fill_data_o  = fill_we_o ? d_data_i : 64'd0;
  assign fill_index_o = line_q[INDEX_W-1:0];
  assign fill_tag_o   = line_q[LINE_W-1:INDEX_W];
  assign fill_perm_o  = cap_q;

endmodule

// File: tb/tb_rv64g_l1_vlsu_refill_engine.sv
// ---------------------------------------------------------------------------
// Self-checking bench for rv64g_l1_vlsu_refill_engine.
// Directed transactions come from a table of {stimulus, expected} records;
// random transactions get their expectations from a transaction-level model.
// A per-cycle protocol tracker (A fired / beats consumed / E fired) decides
// what each handshake output must be on every cycle.
// ---------------------------------------------------------------------------
module tb_rv64g_l1_vlsu_refill_engine;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        refill_req;
  logic [63:0] refill_addr;
  logic        refill_write;
  logic        refill_done;
  logic        refill_err;
  logic        busy;

  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [3:0]  a_source;
  logic [63:0] a_address;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_source;
  logic [3:0]  d_sink;
  logic        d_denied;
  logic        d_corrupt;
  logic [63:0] d_data;

  logic        e_valid;
  logic        e_ready;
  logic [3:0]  e_sink;

  logic        fill_we;
  logic [4:0]  fill_index;
  logic [2:0]  fill_beat;
  logic [63:0] fill_data;
  logic        fill_commit;
  logic [52:0] fill_tag;
  logic [1:0]  fill_perm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv64g_l1_vlsu_refill_engine dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .refill_req_i   (refill_req),
    .refill_addr_i  (refill_addr),
    .refill_write_i (refill_write),
    .refill_done_o  (refill_done),
    .refill_err_o   (refill_err),
    .busy_o         (busy),
    .a_valid_o      (a_valid),
    .a_ready_i      (a_ready),
    .a_opcode_o     (a_opcode),
    .a_param_o      (a_param),
    .a_size_o       (a_size),
    .a_source_o     (a_source),
    .a_address_o    (a_address),
    .d_valid_i      (d_valid),
    .d_ready_o      (d_ready),
    .d_opcode_i     (d_opcode),
    .d_param_i      (d_param),
    .d_source_i     (d_source),
    .d_sink_i       (d_sink),
    .d_denied_i     (d_denied),
    .d_corrupt_i    (d_corrupt),
    .d_data_i       (d_data),
    .e_valid_o      (e_valid),
    .e_ready_i      (e_ready),
    .e_sink_o       (e_sink),
    .fill_we_o      (fill_we),
    .fill_index_o   (fill_index),
    .fill_beat_o    (fill_beat),
    .fill_data_o    (fill_data),
    .fill_commit_o  (fill_commit),
    .fill_tag_o     (fill_tag),
    .fill_perm_o    (fill_perm)
  );

  typedef struct packed {
    int              id;
    logic [63:0]     addr;
    logic            write;
    logic [7:0][2:0] opc;
    logic [7:0][3:0] src;
    logic [7:0][3:0] sink;
    logic [7:0][1:0] prm;
    logic [7:0]      den;
    logic [7:0]      cor;
    logic [7:0][63:0] data;
    int              a_stall;
    int              e_stall;
    int              d_gap_pct;
    logic            hold_req;
    logic            do_abort;
    int              abort_beat;
    logic [63:0]     x_aaddr;
    logic            x_aparam;
    logic [4:0]      x_index;
    logic [52:0]     x_tag;
    logic            x_err;
    logic            x_commit;
    logic [1:0]      x_perm;
    logic [3:0]      x_sink;
    logic [7:0]      x_we_mask;
    logic            chk_cyc;
    int              x_done_cyc;
  } txn_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clean 8-beat GrantData from source 2, beat-0 sink 9 and the given cap.
  function automatic txn_t mk(input int id, input logic [63:0] addr,
                              input logic write, input logic [1:0] p0);
    txn_t v;
    v = '0;
    v.id    = id;
    v.addr  = addr;
    v.write = write;
    for (int i = 0; i < 8; i++) begin
      v.opc[i]  = 3'd5;
      v.src[i]  = 4'd2;
      v.sink[i] = 4'($urandom);
      v.prm[i]  = 2'($urandom);
      v.data[i] = {$urandom, $urandom};
    end
    v.sink[0]    = 4'h9;
    v.prm[0]     = p0;
    v.x_done_cyc = 11;
    return v;
  endfunction

  function automatic txn_t setx(input txn_t v, input logic [63:0] aaddr, input logic ap,
                                input logic [4:0] idx, input logic [52:0] tag,
                                input logic err, input logic commit, input logic [1:0] perm,
                                input logic [7:0] mask, input logic cc);
    v.x_aaddr   = aaddr;
    v.x_aparam  = ap;
    v.x_index   = idx;
    v.x_tag     = tag;
    v.x_err     = err;
    v.x_commit  = commit;
    v.x_perm    = perm;
    v.x_sink    = 4'h9;
    v.x_we_mask = mask;
    v.chk_cyc   = cc;
    return v;
  endfunction

  // Transaction-level reference: line address arithmetic plus per-beat rules.
  function automatic txn_t model(input txn_t v);
    bit ok;
    v.x_aaddr   = v.addr & ~64'h3F;
    v.x_aparam  = v.write;
    v.x_index   = 5'((v.addr / 64) % 32);
    v.x_tag     = 53'(v.addr / 2048);
    v.x_err     = 1'b0;
    v.x_we_mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ok = (v.opc[i] == 3'd5) && (v.src[i] == 4'd2);
      v.x_we_mask[i] = ok;
      if (!ok || v.den[i] || v.cor[i]) v.x_err = 1'b1;
    end
    v.x_commit   = !v.x_err;
    v.x_perm     = v.prm[0];
    v.x_sink     = v.sink[0];
    v.chk_cyc    = (v.a_stall == 0) && (v.e_stall == 0) && (v.d_gap_pct == 0);
    v.x_done_cyc = 11;
    return v;
  endfunction

  task automatic chk_reset_outputs(input string p);
    chk({p, "_done"},     64'(refill_done), 64'd0);
    chk({p, "_err"},      64'(refill_err),  64'd0);
    chk({p, "_busy"},     64'(busy),        64'd0);
    chk({p, "_a_valid"},  64'(a_valid),     64'd0);
    chk({p, "_a_param"},  64'(a_param),     64'd0);
    chk({p, "_a_addr"},   a_address,        64'd0);
    chk({p, "_a_opcode"}, 64'(a_opcode),    64'd6);
    chk({p, "_a_size"},   64'(a_size),      64'd6);
    chk({p, "_a_source"}, 64'(a_source),    64'd2);
    chk({p, "_d_ready"},  64'(d_ready),     64'd0);
    chk({p, "_e_valid"},  64'(e_valid),     64'd0);
    chk({p, "_e_sink"},   64'(e_sink),      64'd0);
    chk({p, "_fill_we"},  64'(fill_we),     64'd0);
    chk({p, "_f_index"},  64'(fill_index),  64'd0);
    chk({p, "_f_beat"},   64'(fill_beat),   64'd0);
    chk({p, "_f_data"},   fill_data,        64'd0);
    chk({p, "_commit"},   64'(fill_commit), 64'd0);
    chk({p, "_f_tag"},    64'(fill_tag),    64'd0);
    chk({p, "_f_perm"},   64'(fill_perm),   64'd0);
  endtask

  task automatic idle_check(input int id, input int n);
    string p;
    p = $sformatf("t%0d_idle", id);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      refill_req = 1'b0;
      d_valid    = 1'b0;
      a_ready    = 1'b1;
      e_ready    = 1'b1;
      #1;
      chk({p, "_busy"},    64'(busy),    64'd0);
      chk({p, "_a_valid"}, 64'(a_valid), 64'd0);
      chk({p, "_e_valid"}, 64'(e_valid), 64'd0);
      chk({p, "_fill_we"}, 64'(fill_we), 64'd0);
    end
  endtask

  task automatic run_txn(input txn_t v);
    int   beat, a_left, e_left;
    bit   a_fired, e_fired, done_seen;
    bit   x_aval, x_dready, x_evalid, x_done, d_hs, x_we;
    string p;
    p = $sformatf("t%0d", v.id);

    @(negedge clk);
    refill_req   = 1'b1;
    refill_addr  = v.addr;
    refill_write = v.write;
    a_ready      = 1'b0;
    d_valid      = 1'b0;
    e_ready      = 1'b0;
    #1;
    chk({p, "_req_busy"},    64'(busy),    64'd0);
    chk({p, "_req_a_valid"}, 64'(a_valid), 64'd0);

    beat = 0; a_left = v.a_stall; e_left = v.e_stall;
    a_fired = 1'b0; e_fired = 1'b0; done_seen = 1'b0;

    for (int cyc = 1; cyc < 300 && !done_seen; cyc++) begin
      @(negedge clk);
      refill_req   = v.hold_req;
      refill_addr  = {$urandom, $urandom};
      refill_write = 1'($urandom);

      if (v.do_abort && a_fired && beat == v.abort_beat) begin
        rst_n      = 1'b0;
        refill_req = 1'b0;
        d_valid    = 1'b0;
        a_ready    = 1'b0;
        e_ready    = 1'b0;
        #1;
        chk_reset_outputs({p, "_abort"});
        return;
      end

      a_ready   = (a_left == 0);
      d_valid   = 1'b0;
      d_opcode  = 3'($urandom);
      d_source  = 4'($urandom);
      d_sink    = 4'($urandom);
      d_param   = 2'($urandom);
      d_denied  = 1'($urandom);
      d_corrupt = 1'($urandom);
      d_data    = {$urandom, $urandom};
      if (a_fired && beat < 8 && int'($urandom_range(99)) >= v.d_gap_pct) begin
        d_valid   = 1'b1;
        d_opcode  = v.opc[beat];
        d_source  = v.src[beat];
        d_sink    = v.sink[beat];
        d_param   = v.prm[beat];
        d_denied  = v.den[beat];
        d_corrupt = v.cor[beat];
        d_data    = v.data[beat];
      end
      e_ready = (e_left == 0);
      #1;

      x_aval   = !a_fired;
      x_dready = a_fired && beat < 8;
      x_evalid = (beat == 8) && !e_fired;
      x_done   = e_fired;
      d_hs     = d_valid && x_dready;
      x_we     = 1'b0;
      if (d_hs) x_we = v.x_we_mask[beat];

      chk({p, "_busy"},    64'(busy),        64'd1);
      chk({p, "_a_valid"}, 64'(a_valid),     64'(x_aval));
      chk({p, "_d_ready"}, 64'(d_ready),     64'(x_dready));
      chk({p, "_e_valid"}, 64'(e_valid),     64'(x_evalid));
      chk({p, "_fill_we"}, 64'(fill_we),     64'(x_we));
      chk({p, "_done"},    64'(refill_done), 64'(x_done));
      chk({p, "_commit"},  64'(fill_commit), 64'(x_done && v.x_commit));

      if (x_aval) begin
        chk({p, "_a_addr"},   a_address,     v.x_aaddr);
        chk({p, "_a_param"},  64'(a_param),  64'(v.x_aparam));
        chk({p, "_a_opcode"}, 64'(a_opcode), 64'd6);
        chk({p, "_a_size"},   64'(a_size),   64'd6);
        chk({p, "_a_source"}, 64'(a_source), 64'd2);
      end
      if (x_we) begin
        chk($sformatf("%s_f_beat%0d", p, beat),  64'(fill_beat),  64'(beat));
        chk($sformatf("%s_f_data%0d", p, beat),  fill_data,       v.data[beat]);
        chk($sformatf("%s_f_index%0d", p, beat), 64'(fill_index), 64'(v.x_index));
      end
      if (x_evalid && v.x_we_mask[0]) begin
        chk({p, "_e_sink"}, 64'(e_sink), 64'(v.x_sink));
      end
      if (x_done) begin
        chk({p, "_err"}, 64'(refill_err), 64'(v.x_err));
        if (v.x_commit) begin
          chk({p, "_tag"},   64'(fill_tag),   64'(v.x_tag));
          chk({p, "_index"}, 64'(fill_index), 64'(v.x_index));
          chk({p, "_perm"},  64'(fill_perm),  64'(v.x_perm));
        end
        if (v.chk_cyc) begin
          chk({p, "_done_cycle"}, 64'(cyc), 64'(v.x_done_cyc));
        end
      end

      if (!a_fired) begin
        if (a_ready) a_fired = 1'b1;
        else         a_left--;
      end
      if (d_hs) beat++;
      if (x_evalid) begin
        if (e_ready) e_fired = 1'b1;
        else         e_left--;
      end
      if (x_done) done_seen = 1'b1;
    end

    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no refill_done expected one within 300 cycles", p);
    end
  endtask

  initial begin
    txn_t tbl [8];
    txn_t v;

    rst_n = 1'b0;
    refill_req = 1'b0; refill_addr = 64'd0; refill_write = 1'b0;
    a_ready = 1'b0; d_valid = 1'b0; e_ready = 1'b0;
    d_opcode = 3'd0; d_param = 2'd0; d_source = 4'd0; d_sink = 4'd0;
    d_denied = 1'b0; d_corrupt = 1'b0; d_data = 64'd0;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Tag of 0x8000_1F40 is 0x8000_1F40 >> 11 = 0x10_0003, index 0x1D.
    tbl[0] = setx(mk(0, 64'h0000_0000_8000_1F7C, 1'b0, 2'd1),
                  64'h8000_1F40, 1'b0, 5'h1D, 53'h10_0003, 1'b0, 1'b1, 2'd1, 8'hFF, 1'b1);
    tbl[1] = setx(mk(1, 64'h0000_0000_8000_1F7C, 1'b0, 2'd1),
                  64'h8000_1F40, 1'b0, 5'h1D, 53'h10_0003, 1'b0, 1'b1, 2'd1, 8'hFF, 1'b0);
    tbl[1].a_stall = 3; tbl[1].d_gap_pct = 40; tbl[1].e_stall = 2;
    tbl[2] = mk(2, 64'h0000_0000_8000_1F7C, 1'b0, 2'd1);
    tbl[2].den[4] = 1'b1;
    tbl[2] = setx(tbl[2], 64'h8000_1F40, 1'b0, 5'h1D, 53'h10_0003, 1'b1, 1'b0, 2'd1, 8'hFF, 1'b1);
    tbl[3] = mk(3, 64'h0000_0000_8000_1F7C, 1'b0, 2'd1);
    tbl[3].opc[2] = 3'd4;
    tbl[3] = setx(tbl[3], 64'h8000_1F40, 1'b0, 5'h1D, 53'h10_0003, 1'b1, 1'b0, 2'd1, 8'hFB, 1'b1);
    tbl[4] = setx(mk(4, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 2'd0),
                  64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 5'h1F, 53'h1F_FFFF_FFFF_FFFF,
                  1'b0, 1'b1, 2'd0, 8'hFF, 1'b1);
    tbl[5] = mk(5, 64'h0000_0000_8000_1F7C, 1'b0, 2'd1);
    tbl[5].src[7] = 4'd3;
    tbl[5] = setx(tbl[5], 64'h8000_1F40, 1'b0, 5'h1D, 53'h10_0003, 1'b1, 1'b0, 2'd1, 8'h7F, 1'b1);
    tbl[6] = mk(6, 64'h0000_0000_8000_1F7C, 1'b0, 2'd2);
    tbl[6].cor[0] = 1'b1;
    tbl[6] = setx(tbl[6], 64'h8000_1F40, 1'b0, 5'h1D, 53'h10_0003, 1'b1, 1'b0, 2'd2, 8'hFF, 1'b1);
    // Request held high across the whole transaction including DONE.
    tbl[7] = setx(mk(7, 64'h0000_1234_5678_9ABF, 1'b1, 2'd0),
                  64'h0000_1234_5678_9A80, 1'b1, 5'h0A, 53'h2_468A_CF13,
                  1'b0, 1'b1, 2'd0, 8'hFF, 1'b1);
    tbl[7].hold_req = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i]);
      idle_check(tbl[i].id, 3);
    end

    // Reset while beat 3 is being presented, then a normal refill.
    v = mk(20, 64'h0000_0000_4000_0A00, 1'b0, 2'd1);
    v.do_abort = 1'b1;
    v.abort_beat = 3;
    v = model(v);
    run_txn(v);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(20, 4);
    v = tbl[0];
    v.id = 21;
    run_txn(v);
    idle_check(21, 1);

    for (int k = 0; k < 40; k++) begin
      v = mk(100 + k, {$urandom, $urandom}, 1'($urandom), 2'($urandom));
      v.sink[0] = 4'($urandom);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(24) == 0) v.opc[i] = 3'd4;
        if ($urandom_range(24) == 0) v.src[i] = 4'd3;
        v.den[i] = ($urandom_range(29) == 0);
        v.cor[i] = ($urandom_range(29) == 0);
      end
      if ($urandom_range(3) != 0) begin
        v.a_stall   = int'($urandom_range(3));
        v.e_stall   = int'($urandom_range(3));
        v.d_gap_pct = int'($urandom_range(50));
      end
      v = model(v);
      run_txn(v);
      idle_check(v.id, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
